// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             mem_redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       state,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam int              WAIT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic              data_wait;
  logic              redirect_hit;
  logic              load_use;
  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  assign data_wait    = mem_access && !dmem_ready;
  assign redirect_hit = !data_wait && mem_redirect;
  assign load_use     = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

  // Priority: freeze > redirect > load-use > fetch wait > normal.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (data_wait) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // A freeze leaving MEM_WAIT with a redirect already pending goes straight to REDIRECT.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (data_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else if (mem_redirect) begin
          state_d = ST_REDIRECT;
        end
      end
      ST_MEM_WAIT: begin
        if (data_wait) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_MAX) mem_err_d = 1'b1;
        end else if (mem_redirect) begin
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        if (data_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else if (!mem_redirect && imem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign state   = state_q;
  assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_hit && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_redirect_hit;
  assign unused_redirect_hit = redirect_hit;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl, ex_mem_fl}
  localparam logic [7:0] C_NORM   = 8'b11111_000;
  localparam logic [7:0] C_FREEZE = 8'b00000_000;
  localparam logic [7:0] C_REDIR  = 8'b11111_111;
  localparam logic [7:0] C_LU     = 8'b00111_010;
  localparam logic [7:0] C_FW     = 8'b01111_100;
  localparam logic [7:0] C_RST    = 8'b00000_111;

  logic clk, rst;
  logic imem_ready, id_use_rs1, id_use_rs2, ex_mem_read, mem_access, dmem_ready, mem_redirect;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] state;
  logic mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctl;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .mem_redirect(mem_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .state(state), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       imem;
    logic [4:0] rs1, rs2;
    logic       u1, u2, mrd;
    logic [4:0] rd;
    logic       macc, dmr, redir;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input string nm, input logic imem, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic mrd, input logic [4:0] rd, input logic macc,
                              input logic dmr, input logic redir, input logic [7:0] exp);
    vec_t v;
    v.name = nm; v.imem = imem; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.mrd = mrd; v.rd = rd; v.macc = macc; v.dmr = dmr; v.redir = redir; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    imem_ready = v.imem; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_mem_read = v.mrd; ex_rd = v.rd;
    mem_access = v.macc; dmem_ready = v.dmr; mem_redirect = v.redir;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NORM));
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t idle_v, lu_v, dw_v, dwr_v, fw_v, rd_v;

  initial begin
    idle_v = mk("idle", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NORM);
    lu_v   = mk("lu",   1, 0, 5, 0, 1, 1, 5, 0, 1, 0, C_LU);
    dw_v   = mk("dw",   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_FREEZE);
    dwr_v  = mk("dwr",  1, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_FREEZE);
    fw_v   = mk("fw",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FW);
    rd_v   = mk("rd",   1, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_REDIR);

    vecs[0]  = mk("normal",            1, 1, 2, 1, 1, 0, 3, 0, 1, 0, C_NORM);
    vecs[1]  = mk("lu_rs2",            1, 0, 5, 0, 1, 1, 5, 0, 1, 0, C_LU);
    vecs[2]  = mk("lu_rd0",            1, 0, 0, 1, 1, 1, 0, 0, 1, 0, C_NORM);
    vecs[3]  = mk("lu_rs1_unused",     1, 7, 0, 0, 0, 1, 7, 0, 1, 0, C_NORM);
    vecs[4]  = mk("lu_rs1",            1, 7, 0, 1, 0, 1, 7, 0, 1, 0, C_LU);
    vecs[5]  = mk("match_no_load",     1, 7, 7, 1, 1, 0, 7, 0, 1, 0, C_NORM);
    vecs[6]  = mk("fetch_wait",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FW);
    vecs[7]  = mk("lu_over_fetch",     0, 9, 9, 0, 1, 1, 9, 0, 1, 0, C_LU);
    vecs[8]  = mk("redir_over_lu",     1, 9, 9, 1, 1, 1, 9, 0, 1, 1, C_REDIR);
    vecs[9]  = mk("redir_mem_ready",   0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_REDIR);
    vecs[10] = mk("freeze_over_redir", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_FREEZE);
    vecs[11] = mk("data_wait_all",     0, 5, 5, 1, 1, 1, 5, 1, 0, 0, C_FREEZE);
    vecs[12] = mk("mem_done",          1, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_NORM);
    vecs[13] = mk("rs_mismatch",       1, 4, 6, 1, 1, 1, 5, 0, 1, 0, C_NORM);

    rst = 1'b1;
    drive(idle_v);
    #2;
    chk("reset_ctl", ctl, C_RST);
    chk("reset_state", state, 0);
    chk("reset_err", mem_err, 0);
    chk("reset_stall", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk(vecs[i].name, ctl, vecs[i].exp);
    end

    // Load-use: one stall cycle, then the pipeline resumes
    do_reset();
    drive(lu_v); #2;
    chk("lu_seq_stall", ctl, C_LU);
    @(negedge clk); drive(idle_v); #2;
    chk("lu_seq_resume", ctl, C_NORM);
    chk("lu_seq_state", state, 0);
    @(negedge clk); #2;
    chk("lu_seq_stall_cnt", stall_cnt, PERF ? 1 : 0);

    // Data wait for three cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      drive(dw_v); #2;
      chk("dw_freeze", ctl, C_FREEZE);
      chk("dw_state", state, (i == 0) ? 0 : 1);
    end
    @(negedge clk); dmem_ready = 1'b1; #2;
    chk("dw_exit_ctl", ctl, C_NORM);
    chk("dw_exit_state", state, 1);
    @(negedge clk); drive(idle_v); #2;
    chk("dw_run_state", state, 0);
    chk("dw_stall_cnt", stall_cnt, PERF ? 3 : 0);
    chk("dw_err", mem_err, 0);

    // Timeout with MEM_TIMEOUT=4
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      drive(dw_v); #2;
      chk("to_err", mem_err, (i >= 5) ? 1 : 0);
      chk("to_freeze", ctl, C_FREEZE);
    end
    @(negedge clk); dmem_ready = 1'b1; #2;
    chk("to_release_ctl", ctl, C_NORM);
    chk("to_sticky1", mem_err, 1);
    @(negedge clk); drive(idle_v); #2;
    chk("to_sticky2", mem_err, 1);
    chk("to_state", state, 0);

    // Async reset in the middle of MEM_WAIT
    @(negedge clk); drive(dw_v);
    @(negedge clk); #2;
    chk("ar_state_before", state, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_ctl", ctl, C_RST);
    chk("ar_state", state, 0);
    chk("ar_err", mem_err, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_flush", flush_cnt, 0);
    @(negedge clk);
    drive(idle_v);
    rst = 1'b0;

    // Redirect followed by a slow target fetch
    do_reset();
    drive(rd_v); #2;
    chk("rf_c0_ctl", ctl, C_REDIR);
    chk("rf_c0_state", state, 0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk); drive(fw_v); #2;
      chk("rf_fetch_ctl", ctl, C_FW);
      chk("rf_fetch_state", state, 2);
    end
    @(negedge clk); drive(idle_v); #2;
    chk("rf_c3_ctl", ctl, C_NORM);
    chk("rf_c3_state", state, 2);
    @(negedge clk); #2;
    chk("rf_c4_state", state, 0);
    chk("rf_flush_cnt", flush_cnt, PERF ? 1 : 0);
    chk("rf_stall_cnt", stall_cnt, PERF ? 2 : 0);

    // Redirect coinciding with a data wait
    do_reset();
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      drive(dwr_v); #2;
      chk("sim_freeze", ctl, C_FREEZE);
    end
    chk("sim_flush_none", flush_cnt, 0);
    @(negedge clk); dmem_ready = 1'b1; #2;
    chk("sim_redirect", ctl, C_REDIR);
    @(negedge clk); drive(idle_v); #2;
    chk("sim_flush_cnt", flush_cnt, PERF ? 1 : 0);
    chk("sim_stall_cnt", stall_cnt, PERF ? 2 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
